// File: rtl/misr_signature_analyzer.sv
// 5-bit MISR output-response analyzer: compacts CUT responses into a signature,
// counts patterns and compares the final signature against a golden value.
module misr_signature_analyzer #(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] SEED       = 5'b11111,
  parameter int               N_PATTERNS = 31,
  parameter int               CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  input  logic [WIDTH-1:0] golden,
  output logic             gen_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;

  // Taps match the x^5 + x^3 + 1 generator so zero responses replay its sequence.
  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] n;
    n[0]         = s[4] ^ s[2] ^ d[0];
    n[WIDTH-1:1] = s[WIDTH-2:0] ^ d[WIDTH-1:1];
    return n;
  endfunction

  // State, signature, counter and verdict registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= {CNT_W{1'b0}};
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and datapath control; abort outranks start and resp_valid.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            sig_d   = SEED;
            cnt_d   = {CNT_W{1'b0}};
            pass_d  = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          if (resp_valid) begin
            sig_d = misr_next(sig_q, resp_data);
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_CNT) begin
              state_d = CHECK;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        CHECK: begin
          pass_d  = (sig_q == golden);
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign gen_en    = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_count = cnt_q;

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Scoreboard bench for misr_signature_analyzer: the driver queues expectations,
// a negedge monitor pops and compares them when the DUT accepts or finishes.
module tb_misr_signature_analyzer;

  localparam logic [4:0]  SEED   = 5'b11111;
  localparam logic [13:0] M_SIG  = 14'h03E0;
  localparam logic [13:0] M_CNT  = 14'h001F;
  localparam logic [13:0] M_CTRL = 14'h3C00;
  localparam logic [13:0] M_ALL  = 14'h3FFF;

  typedef struct {
    string       name;
    logic [13:0] exp;
    logic [13:0] mask;
  } probe_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       resp_valid = 1'b0;
  logic [4:0] resp_data = 5'd0;
  logic [4:0] golden = 5'd0;
  logic       gen_en, busy, done, pass;
  logic [4:0] signature;
  logic [4:0] pat_count;
  logic [13:0] obs;

  logic [9:0] acc_q[$];
  logic [5:0] done_q[$];
  probe_t     probe_q[$];
  logic [4:0] vec[31];

  int checks = 0;
  int errors = 0;
  bit prev_acc = 1'b0;
  bit done_prev = 1'b0;
  bit end_req = 1'b0;
  bit end_done = 1'b0;

  misr_signature_analyzer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp_data(resp_data), .golden(golden),
    .gen_en(gen_en), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  assign obs = {gen_en, busy, done, pass, signature, pat_count};

  function automatic logic [4:0] misr_ref(input logic [4:0] s, input logic [4:0] d);
    logic [4:0] n;
    n[0] = s[4] ^ s[2] ^ d[0];
    for (int i = 1; i < 5; i++) n[i] = s[i-1] ^ d[i];
    return n;
  endfunction

  function automatic logic [13:0] pk(input logic g, input logic b, input logic d,
                                     input logic p, input logic [4:0] s, input logic [4:0] c);
    return {g, b, d, p, s, c};
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    logic [9:0]  ea;
    logic [5:0]  ed;
    probe_t      pr;
    if (prev_acc) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_accept: got accept with sig=%h cnt=%0d, required none", signature, pat_count);
      end else begin
        ea = acc_q.pop_front();
        if ({signature, pat_count} !== ea) begin
          errors++;
          $display("FAIL accept: got sig=%h cnt=%0d, required sig=%h cnt=%0d", signature, pat_count, ea[9:5], ea[4:0]);
        end
      end
    end
    if (done && !done_prev) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with sig=%h pass=%b, required none", signature, pass);
      end else begin
        ed = done_q.pop_front();
        if ({signature, pass} !== ed) begin
          errors++;
          $display("FAIL done_result: got sig=%h pass=%b, required sig=%h pass=%b", signature, pass, ed[5:1], ed[0]);
        end
      end
    end
    while (probe_q.size() > 0) begin
      pr = probe_q.pop_front();
      checks++;
      if ((obs & pr.mask) !== (pr.exp & pr.mask)) begin
        errors++;
        $display("FAIL %s: got %h, required %h (mask %h)", pr.name, obs & pr.mask, pr.exp & pr.mask, pr.mask);
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (acc_q.size() != 0 || done_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d accepts and %0d results outstanding, required 0 and 0", acc_q.size(), done_q.size());
      end
      end_done = 1'b1;
    end
    prev_acc  = rst && gen_en && resp_valid && !abort;
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string n, input logic [13:0] e, input logic [13:0] m);
    probe_t p;
    p.name = n;
    p.exp  = e;
    p.mask = m;
    probe_q.push_back(p);
  endtask

  task automatic do_run(input logic [4:0] gold, input bit stall, input bit hand);
    logic [4:0] m;
    golden = gold;
    m = SEED;
    start = 1'b1;
    tick();
    start = 1'b0;
    probe("run_entry", pk(1'b1, 1'b1, 1'b0, 1'b0, SEED, 5'd0), M_ALL);
    for (int i = 0; i < 31; i++) begin
      if (stall && i > 0) begin
        resp_valid = 1'b0;
        resp_data  = 5'h15;
        tick();
        probe("stall_hold", pk(1'b1, 1'b1, 1'b0, 1'b0, m, 5'(i)), M_SIG | M_CNT);
      end
      resp_valid = 1'b1;
      resp_data  = vec[i];
      m = misr_ref(m, vec[i]);
      acc_q.push_back({m, 5'(i + 1)});
      tick();
      if (hand && i == 0) probe("hand_acc1", pk(1'b0, 1'b0, 1'b0, 1'b0, 5'b11110, 5'd1), M_SIG | M_CNT);
      if (hand && i == 1) probe("hand_acc2", pk(1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'd2), M_SIG | M_CNT);
    end
    resp_valid = 1'b0;
    resp_data  = 5'd0;
    done_q.push_back({m, m == gold});
    probe("check_state", pk(1'b0, 1'b1, 1'b0, 1'b0, m, 5'd31), M_ALL);
    tick();
    probe("done_state", pk(1'b0, 1'b0, 1'b1, m == gold, m, 5'd31), M_ALL);
    if (hand) probe("hand_final", pk(1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 5'd31), M_ALL);
    tick();
  endtask

  initial begin
    logic [4:0] m;
    #2;
    probe("reset_init", pk(1'b0, 1'b0, 1'b0, 1'b0, SEED, 5'd0), M_ALL);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    probe("idle_after_reset", pk(1'b0, 1'b0, 1'b0, 1'b0, SEED, 5'd0), M_ALL);

    // All-zero responses, golden = seed.
    for (int i = 0; i < 31; i++) vec[i] = 5'd0;
    do_run(5'b11111, 1'b0, 1'b1);

    // Constant 00001 keeps the signature at the seed.
    for (int i = 0; i < 31; i++) vec[i] = 5'b00001;
    do_run(5'b11111, 1'b0, 1'b0);

    // Single corrupted response on pattern 10 must fail.
    for (int i = 0; i < 31; i++) vec[i] = 5'd0;
    vec[9] = 5'b00001;
    do_run(5'b11111, 1'b0, 1'b0);

    // Stalls between every accept, zero data.
    for (int i = 0; i < 31; i++) vec[i] = 5'd0;
    do_run(5'b11111, 1'b1, 1'b1);

    // Abort at pat_count 7 together with start; start during RUN ignored.
    golden = 5'b11111;
    m = SEED;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      resp_valid = 1'b1;
      resp_data  = 5'd0;
      start = (i == 3);
      m = misr_ref(m, 5'd0);
      acc_q.push_back({m, 5'(i + 1)});
      tick();
      start = 1'b0;
    end
    probe("pre_abort", pk(1'b1, 1'b1, 1'b0, 1'b0, m, 5'd7), M_ALL);
    abort = 1'b1;
    start = 1'b1;
    resp_valid = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    probe("abort_idle", pk(1'b0, 1'b0, 1'b0, 1'b0, m, 5'd7), M_ALL);
    tick();
    tick();
    probe("idle_ignores_resp", pk(1'b0, 1'b0, 1'b0, 1'b0, m, 5'd7), M_ALL);
    resp_valid = 1'b0;
    tick();
    do_run(5'b11111, 1'b0, 1'b1);

    // Asynchronous reset mid-run.
    m = SEED;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      resp_valid = 1'b1;
      resp_data  = 5'd0;
      m = misr_ref(m, 5'd0);
      acc_q.push_back({m, 5'(i + 1)});
      tick();
    end
    resp_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    probe("reset_async", pk(1'b0, 1'b0, 1'b0, 1'b0, SEED, 5'd0), M_ALL);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    probe("idle_after_mid_reset", pk(1'b0, 1'b0, 1'b0, 1'b0, SEED, 5'd0), M_ALL);
    tick();

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if (!end_done) begin
      errors++;
      $display("FAIL end_sync: got no final queue check, required one");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
